cpu_data_path: RTL and testbench
================================

Name: cpu_data_path

Overview:
- 32-bit single-bus CPU datapath with:
  - 16 general registers R0–R15
  - PC, HI, LO, Y, Z (Zhigh/Zlow), MDR and InPort registers
  - 5-bit-opcode ALU
- Each source register drives the shared bus through a one-hot mux. Each destination register loads from the bus on its `*in` strobe.
- Driven cycle by cycle by an external control unit (or a bench); every register value is exported for observation.

Parameters:
- WIDTH, 32, data/bus width (fixed; ALU product is 2*WIDTH)

Ports:
- Clock  input  1  rising-edge clock
- clear  input  1  asynchronous active-low reset
- Read  input  1  MDR input select: 1 = Mdatain, 0 = bus
- op  input  5  ALU opcode
- Mdatain  input  32  memory read data
- R0out..R15out  input  1 each  drive Rn onto bus
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout  input  1 each  drive that register onto bus
- R0in..R15in  input  1 each  load Rn from bus
- HIin, LOin, ZHighin, Zlowin, IncPC, MDRin, InPortin, Yin  input  1 each  load enables; IncPC = PC increment, see Behaviour
- BusOut  output  32  current bus value
- mdrData  output  32  MDR contents
- BusMuxInR0..BusMuxInR15  output  32 each  register contents
- BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout, BusMuxInInPortout, BusMuxInYout, BusMuxInHI, BusMuxInLO  output  32 each  register contents

Behaviour:
- Reset: clear=0 asynchronously zeroes every register, so every BusMuxIn*/mdrData output is 0. BusOut is 0 while no `*out` strobe is asserted.
- Bus:
  - Combinational.
  - Fixed priority when several `*out` strobes are asserted: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, Y (first wins).
  - No strobe asserted: BusOut = 0.
- Register loads:
  - All loads happen on the rising Clock edge while the strobe is 1; otherwise the register holds.
  - Each register loads BusOut, with the exceptions below.
- MDR: loads (Read ? Mdatain : BusOut) when MDRin=1.
- Y: loads BusOut when Yin=1; Y is ALU operand A. Operand B = BusOut.
- ALU is combinational and produces a 64-bit result C. Shifts use B[4:0].
  - 00000 ADD: A+B
  - 00001 SUB: A-B
  - 00010 AND
  - 00011 OR
  - 00100 SHR: logical right, A>>B
  - 00101 SHRA: arithmetic right, A>>>B
  - 00110 SHL: A<<B
  - 00111 ROR
  - 01000 ROL
  - 01001 MUL: signed A*B, full 64 bits
  - 01010 DIV: signed; C[31:0]=quotient, C[63:32]=remainder. B=0 gives quotient 32'hFFFFFFFF and remainder = A.
  - 01011 NEG: -B
  - 01100 NOT: ~B
  - Undefined opcodes give C=0.
  - Non-MUL/DIV results: C[63:32] = 0.
- Z loads: Zlowin loads C[31:0] into Zlow; ZHighin loads C[63:32] into Zhigh. Either or both may load in the same cycle.
- IncPC=1 on an edge: PC <= PC+1 (wraps 32'hFFFFFFFF -> 0). IncPC takes precedence over a simultaneous PCin.
- Simultaneous `*in` strobes: every enabled register loads the same bus value.
- A register may both drive the bus and load in the same cycle; it captures the bus value (its old value when it is the bus source).
- Reset asserted mid-sequence overrides any load.

Optional Feature:
- Macro R0_ZERO_EN.
- Defined:
  - R0 never loads (R0in ignored) and reads as 0.
  - BusMuxInR0 = 0.
  - R0out drives 0 onto the bus and keeps its priority slot.
- Undefined: R0 is an ordinary register.

Decomposition:
- Package cpu_pkg: ALU opcode localparams (ADD..NOT), WIDTH constant, bus-source priority order.
- Sub-modules:
  - cpu_alu: combinational, A/B/op -> 64-bit C.
  - Registers are inline always blocks or a small cpu_reg32 with async-low clear and load enable.

Test Plan:
- Reset: clear=0 with all strobes random -> every BusMuxIn*, mdrData and BusOut = 0; after release, registers hold 0.
- Load path: Mdatain=12, Read=1, MDRin=1 -> mdrData=12. Then MDRout+R3in -> R3=12. Then R3out+Yin -> Y=12. Repeat with Mdatain=5 into R2.
- SHRA: Y=12, R2=5, op=00101, R2out+Zlowin -> Zlow=0. Then Zlowout+R1in -> R1=0. Repeat with Y=32'hFFFFFF00, R2=4 -> Zlow=32'hFFFFFFF0.
- MUL/DIV: Y=-3, B=7, op=01001 with Zlowin+ZHighin -> Zlow=32'hFFFFFFEB, Zhigh=32'hFFFFFFFF. DIV of 17/5 -> Zlow=3, Zhigh=2. DIV by 0 -> Zlow=32'hFFFFFFFF, Zhigh=17.
- Bus priority/idle: R1out+MDRout asserted together -> BusOut = R1. No `*out` strobe -> BusOut=0. PC=32'hFFFFFFFF, IncPC -> PC=0.
- R0_ZERO_EN build: MDR=9, MDRout+R0in -> BusMuxInR0=0. Non-macro build -> 9.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the single-bus CPU datapath: width, ALU opcodes and
// the bus-source slot order (lower slot wins when several sources drive).
package cpu_pkg;
    localparam int WIDTH   = 32;
    localparam int NUM_GPR = 16;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_NEG  = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;

    // Slots 0..15 are R0..R15.
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_Y      = 23;
    localparam int NUM_SRC    = 24;
endpackage

// File: rtl/cpu_data_path_if.sv
// Control strobes from the control unit plus every register value exported
// back for observation. Bit n of Rout/Rin/BusMuxInR belongs to register Rn.
interface cpu_data_path_if;
    import cpu_pkg::*;

    logic                            Read;
    logic [4:0]                      op;
    logic [WIDTH-1:0]                Mdatain;
    logic [NUM_GPR-1:0]              Rout;
    logic [NUM_GPR-1:0]              Rin;
    logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout;
    logic HIin, LOin, ZHighin, Zlowin, IncPC, PCin, MDRin, InPortin, Yin;

    logic [WIDTH-1:0]                BusOut;
    logic [WIDTH-1:0]                mdrData;
    logic [NUM_GPR-1:0][WIDTH-1:0]   BusMuxInR;
    logic [WIDTH-1:0] BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout, BusMuxInInPortout;
    logic [WIDTH-1:0] BusMuxInYout, BusMuxInHI, BusMuxInLO;

    modport master (
        output Read, op, Mdatain, Rout, Rin,
               HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout,
               HIin, LOin, ZHighin, Zlowin, IncPC, PCin, MDRin, InPortin, Yin,
        input  BusOut, mdrData, BusMuxInR, BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout,
               BusMuxInInPortout, BusMuxInYout, BusMuxInHI, BusMuxInLO
    );

    modport slave (
        input  Read, op, Mdatain, Rout, Rin,
               HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout,
               HIin, LOin, ZHighin, Zlowin, IncPC, PCin, MDRin, InPortin, Yin,
        output BusOut, mdrData, BusMuxInR, BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout,
               BusMuxInInPortout, BusMuxInYout, BusMuxInHI, BusMuxInLO
    );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: A is the Y register, B is the bus. 64-bit result; only
// MUL/DIV populate the upper half.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [4:0]         i_op,
    output logic [2*WIDTH-1:0] o_c
);
    logic [4:0]         w_sh;
    logic [2*WIDTH-1:0] w_a_ext, w_b_ext;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_sh    = i_b[4:0];
    // Low 64 bits of the sign-extended product equal the signed product.
    assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_quo   = $signed(i_a) / $signed(i_b);
    assign w_rem   = $signed(i_a) % $signed(i_b);

    always_comb begin
        o_c = '0;
        case (i_op)
            OP_ADD:  o_c[WIDTH-1:0] = i_a + i_b;
            OP_SUB:  o_c[WIDTH-1:0] = i_a - i_b;
            OP_AND:  o_c[WIDTH-1:0] = i_a & i_b;
            OP_OR:   o_c[WIDTH-1:0] = i_a | i_b;
            OP_SHR:  o_c[WIDTH-1:0] = i_a >> w_sh;
            OP_SHRA: o_c[WIDTH-1:0] = $signed(i_a) >>> w_sh;
            OP_SHL:  o_c[WIDTH-1:0] = i_a << w_sh;
            OP_ROR:  o_c[WIDTH-1:0] = (i_a >> w_sh) | (i_a << (WIDTH - int'(w_sh)));
            OP_ROL:  o_c[WIDTH-1:0] = (i_a << w_sh) | (i_a >> (WIDTH - int'(w_sh)));
            OP_MUL:  o_c = w_a_ext * w_b_ext;
            OP_DIV:  o_c = (i_b == '0) ? {i_a, {WIDTH{1'b1}}} : {w_rem, w_quo};
            OP_NEG:  o_c[WIDTH-1:0] = -i_b;
            OP_NOT:  o_c[WIDTH-1:0] = ~i_b;
            default: o_c = '0;
        endcase
    end
endmodule

// File: rtl/cpu_data_path.sv
// Single-bus CPU datapath: priority bus mux, register file and Z capture.
// Build option R0_ZERO_EN hardwires R0 to zero (loads ignored, reads as 0).
module cpu_data_path
    import cpu_pkg::*;
(
    input  logic           Clock,
    input  logic           clear,
    cpu_data_path_if.slave io
);
    logic [NUM_GPR-1:0][WIDTH-1:0] r_gpr;
    logic [WIDTH-1:0] r_hi, r_lo, r_zhi, r_zlo, r_pc, r_mdr, r_inport, r_y;

    logic [NUM_SRC-1:0][WIDTH-1:0] w_src;
    logic [NUM_SRC-1:0]            w_sel;
    logic [WIDTH-1:0]              w_bus;
    logic [2*WIDTH-1:0]            w_c;
    logic [NUM_GPR-1:0]            w_gpr_we;

`ifdef R0_ZERO_EN
    localparam logic [NUM_GPR-1:0] GPR_LOCK = NUM_GPR'(1);
`else
    localparam logic [NUM_GPR-1:0] GPR_LOCK = '0;
`endif

    // A locked R0 never leaves reset, so it drives 0 from its own slot.
    assign w_gpr_we = io.Rin & ~GPR_LOCK;

    always_comb begin
        w_src                     = '0;
        w_src[NUM_GPR-1:0]        = r_gpr;
        w_src[SRC_HI]             = r_hi;
        w_src[SRC_LO]             = r_lo;
        w_src[SRC_ZHI]            = r_zhi;
        w_src[SRC_ZLO]            = r_zlo;
        w_src[SRC_PC]             = r_pc;
        w_src[SRC_MDR]            = r_mdr;
        w_src[SRC_INPORT]         = r_inport;
        w_src[SRC_Y]              = r_y;
        w_sel                     = '0;
        w_sel[NUM_GPR-1:0]        = io.Rout;
        w_sel[SRC_HI]             = io.HIout;
        w_sel[SRC_LO]             = io.LOout;
        w_sel[SRC_ZHI]            = io.Zhighout;
        w_sel[SRC_ZLO]            = io.Zlowout;
        w_sel[SRC_PC]             = io.PCout;
        w_sel[SRC_MDR]            = io.MDRout;
        w_sel[SRC_INPORT]         = io.InPortout;
        w_sel[SRC_Y]              = io.Yout;
    end

    // Scan from the lowest-priority slot so the lowest asserted slot wins.
    always_comb begin
        w_bus = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (w_sel[i]) w_bus = w_src[i];
    end

    cpu_alu u_alu (
        .i_a  (r_y),
        .i_b  (w_bus),
        .i_op (io.op),
        .o_c  (w_c)
    );

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_gpr    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_zhi    <= '0;
            r_zlo    <= '0;
            r_pc     <= '0;
            r_mdr    <= '0;
            r_inport <= '0;
            r_y      <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++)
                if (w_gpr_we[i]) r_gpr[i] <= w_bus;
            if (io.HIin)     r_hi     <= w_bus;
            if (io.LOin)     r_lo     <= w_bus;
            if (io.InPortin) r_inport <= w_bus;
            if (io.Yin)      r_y      <= w_bus;
            if (io.MDRin)    r_mdr    <= io.Read ? io.Mdatain : w_bus;
            if (io.Zlowin)   r_zlo    <= w_c[WIDTH-1:0];
            if (io.ZHighin)  r_zhi    <= w_c[2*WIDTH-1:WIDTH];
            if (io.IncPC)     r_pc    <= r_pc + 1'b1;
            else if (io.PCin) r_pc    <= w_bus;
        end
    end

    assign io.BusOut            = w_bus;
    assign io.mdrData           = r_mdr;
    assign io.BusMuxInR         = r_gpr;
    assign io.BusMuxInZhigh     = r_zhi;
    assign io.BusMuxInZlow      = r_zlo;
    assign io.BusMuxInPCout     = r_pc;
    assign io.BusMuxInInPortout = r_inport;
    assign io.BusMuxInYout      = r_y;
    assign io.BusMuxInHI        = r_hi;
    assign io.BusMuxInLO        = r_lo;
endmodule

// File: tb/tb_cpu_data_path.sv
// Bench for cpu_data_path: ALU vector table through a result scoreboard plus
// hand sequences for reset, load paths, bus priority, PC wrap and R0 handling.
module tb_cpu_data_path;
    import cpu_pkg::*;

    logic Clock = 1'b0;
    logic clear;
    always #5 Clock = ~Clock;

    cpu_data_path_if u_if ();
    cpu_data_path u_dut (.Clock(Clock), .clear(clear), .io(u_if));

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a, b, lo, hi;
    } vec_t;

    localparam int NV = 18;
    vec_t        tv [NV];
    logic [63:0] sb [$];
    logic [63:0] exp_c;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        u_if.Read = 0; u_if.op = '0; u_if.Mdatain = '0; u_if.Rout = '0; u_if.Rin = '0;
        {u_if.HIout, u_if.LOout, u_if.Zhighout, u_if.Zlowout,
         u_if.PCout, u_if.MDRout, u_if.InPortout, u_if.Yout} = '0;
        {u_if.HIin, u_if.LOin, u_if.ZHighin, u_if.Zlowin, u_if.IncPC,
         u_if.PCin, u_if.MDRin, u_if.InPortin, u_if.Yin} = '0;
    endtask

    task automatic cyc();
        @(posedge Clock); #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        u_if.Read = 1; u_if.Mdatain = v; u_if.MDRin = 1;
        cyc();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        u_if.MDRout = 1; u_if.Yin = 1;
        cyc();
    endtask

    initial begin
        tv[0]  = '{OP_ADD,  32'd7,        32'd5,        32'd12,       32'd0};
        tv[1]  = '{OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 32'd0};
        tv[2]  = '{OP_AND,  32'hF0F0FFFF, 32'h0FF00F0F, 32'h00F00F0F, 32'd0};
        tv[3]  = '{OP_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F, 32'd0};
        tv[4]  = '{OP_SHR,  32'h80000000, 32'd4,        32'h08000000, 32'd0};
        tv[5]  = '{OP_SHRA, 32'h80000000, 32'd4,        32'hF8000000, 32'd0};
        tv[6]  = '{OP_SHL,  32'd1,        32'd31,       32'h80000000, 32'd0};
        tv[7]  = '{OP_SHL,  32'd1,        32'd33,       32'd2,        32'd0};
        tv[8]  = '{OP_ROR,  32'd1,        32'd1,        32'h80000000, 32'd0};
        tv[9]  = '{OP_ROR,  32'h12345678, 32'd32,       32'h12345678, 32'd0};
        tv[10] = '{OP_ROL,  32'h80000001, 32'd4,        32'h00000018, 32'd0};
        tv[11] = '{OP_MUL,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF};
        tv[12] = '{OP_MUL,  32'h00010000, 32'h00010000, 32'd0,        32'd1};
        tv[13] = '{OP_DIV,  32'd17,       32'd5,        32'd3,        32'd2};
        tv[14] = '{OP_DIV,  32'd17,       32'd0,        32'hFFFFFFFF, 32'd17};
        tv[15] = '{OP_DIV,  32'hFFFFFFEF, 32'd5,        32'hFFFFFFFD, 32'hFFFFFFFE};
        tv[16] = '{OP_NEG,  32'd9,        32'd1,        32'hFFFFFFFF, 32'd0};
        tv[17] = '{5'b11111, 32'd1,       32'd1,        32'd0,        32'd0};

        // Reset with every strobe scrambled
        clear = 0;
        u_if.Read = 1'($urandom); u_if.op = 5'($urandom); u_if.Mdatain = $urandom;
        u_if.Rout = 16'($urandom); u_if.Rin = 16'($urandom);
        {u_if.HIout, u_if.LOout, u_if.Zhighout, u_if.Zlowout,
         u_if.PCout, u_if.MDRout, u_if.InPortout, u_if.Yout} = 8'($urandom);
        {u_if.HIin, u_if.LOin, u_if.ZHighin, u_if.Zlowin, u_if.IncPC,
         u_if.PCin, u_if.MDRin, u_if.InPortin, u_if.Yin} = 9'($urandom);
        repeat (2) @(posedge Clock);
        #1;
        for (int i = 0; i < NUM_GPR; i++) chk($sformatf("rst_R%0d", i), u_if.BusMuxInR[i], '0);
        chk("rst_zhi", u_if.BusMuxInZhigh, '0);
        chk("rst_zlo", u_if.BusMuxInZlow, '0);
        chk("rst_pc",  u_if.BusMuxInPCout, '0);
        chk("rst_inp", u_if.BusMuxInInPortout, '0);
        chk("rst_y",   u_if.BusMuxInYout, '0);
        chk("rst_hi",  u_if.BusMuxInHI, '0);
        chk("rst_lo",  u_if.BusMuxInLO, '0);
        chk("rst_mdr", u_if.mdrData, '0);
        chk("rst_bus", u_if.BusOut, '0);
        idle();
        clear = 1;
        cyc();
        chk("post_rst_R5",  u_if.BusMuxInR[5], '0);
        chk("post_rst_mdr", u_if.mdrData, '0);

        // Load path MDR -> R3 -> Y, then MDR -> R2
        load_mdr(32'd12);
        chk("mdr_12", u_if.mdrData, 32'd12);
        u_if.MDRout = 1; u_if.Rin[3] = 1; cyc();
        chk("r3_12", u_if.BusMuxInR[3], 32'd12);
        u_if.Rout[3] = 1; u_if.Yin = 1; cyc();
        chk("y_12", u_if.BusMuxInYout, 32'd12);
        load_mdr(32'd5);
        u_if.MDRout = 1; u_if.Rin[2] = 1; cyc();
        chk("r2_5", u_if.BusMuxInR[2], 32'd5);

        // SHRA through Zlow and back into R1
        u_if.Rout[2] = 1; u_if.op = OP_SHRA; u_if.Zlowin = 1; cyc();
        chk("shra_12_5", u_if.BusMuxInZlow, 32'd0);
        u_if.Zlowout = 1; u_if.Rin[1] = 1; cyc();
        chk("r1_zero", u_if.BusMuxInR[1], 32'd0);
        load_y(32'hFFFFFF00);
        load_mdr(32'd4);
        u_if.MDRout = 1; u_if.Rin[2] = 1; cyc();
        u_if.Rout[2] = 1; u_if.op = OP_SHRA; u_if.Zlowin = 1; cyc();
        chk("shra_neg", u_if.BusMuxInZlow, 32'hFFFFFFF0);
        u_if.Zlowout = 1; u_if.Rin[1] = 1; cyc();
        chk("r1_fff0", u_if.BusMuxInR[1], 32'hFFFFFFF0);

        // ALU table: expected result queued at drive, popped after capture
        for (int i = 0; i < NV; i++) begin
            load_y(tv[i].a);
            load_mdr(tv[i].b);
            u_if.MDRout = 1; u_if.op = tv[i].op; u_if.Zlowin = 1; u_if.ZHighin = 1;
            sb.push_back({tv[i].hi, tv[i].lo});
            cyc();
            exp_c = sb.pop_front();
            chk($sformatf("alu%0d_lo", i), u_if.BusMuxInZlow, exp_c[31:0]);
            chk($sformatf("alu%0d_hi", i), u_if.BusMuxInZhigh, exp_c[63:32]);
        end

        // Bus priority and idle bus
        load_mdr(32'h000000A5);
        u_if.MDRout = 1; u_if.Rin[1] = 1; cyc();
        load_mdr(32'h00000077);
        u_if.Rout[1] = 1; u_if.MDRout = 1; #1;
        chk("prio_r1_mdr", u_if.BusOut, 32'h000000A5);
        u_if.Rout[1] = 0; u_if.Yout = 1; #1;
        chk("prio_mdr_y", u_if.BusOut, 32'h00000077);
        idle(); #1;
        chk("bus_idle", u_if.BusOut, 32'd0);

        // PC wrap and IncPC precedence over PCin
        load_mdr(32'hFFFFFFFF);
        u_if.MDRout = 1; u_if.PCin = 1; cyc();
        chk("pc_load", u_if.BusMuxInPCout, 32'hFFFFFFFF);
        u_if.IncPC = 1; cyc();
        chk("pc_wrap", u_if.BusMuxInPCout, 32'd0);
        u_if.MDRout = 1; u_if.PCin = 1; u_if.IncPC = 1; cyc();
        chk("pc_inc_prec", u_if.BusMuxInPCout, 32'd1);

        // Self-load plus simultaneous destinations
        u_if.Rout[3] = 1; u_if.Rin[3] = 1; u_if.Rin[4] = 1; u_if.HIin = 1; cyc();
        chk("self_r3", u_if.BusMuxInR[3], 32'd12);
        chk("multi_r4", u_if.BusMuxInR[4], 32'd12);
        chk("multi_hi", u_if.BusMuxInHI, 32'd12);

        // R0 load and R0 bus slot
        load_mdr(32'd9);
        u_if.MDRout = 1; u_if.Rin[0] = 1; cyc();
        u_if.Rout[0] = 1; u_if.Rout[1] = 1; #1;
`ifdef R0_ZERO_EN
        chk("r0_load", u_if.BusMuxInR[0], 32'd0);
        chk("r0_bus",  u_if.BusOut, 32'd0);
`else
        chk("r0_load", u_if.BusMuxInR[0], 32'd9);
        chk("r0_bus",  u_if.BusOut, 32'd9);
`endif
        idle();

        // Reset asserted while a load is pending
        u_if.Read = 1; u_if.Mdatain = 32'd99; u_if.MDRin = 1;
        #2 clear = 0;
        #1;
        chk("midrst_mdr", u_if.mdrData, 32'd0);
        chk("midrst_r3",  u_if.BusMuxInR[3], 32'd0);
        @(posedge Clock); #1;
        chk("midrst_hold", u_if.mdrData, 32'd0);
        idle();
        clear = 1;
        cyc();
        chk("midrst_y", u_if.BusMuxInYout, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
